mips_cycle_controller: RTL and testbench
========================================

Name: mips_cycle_controller

Overview:
- Multi-cycle sequencer for the MIPS core.
- Generates the 2-bit `state` consumed by the instruction decoder (FETCH/EXEC1/EXEC2/HALT).
- Handles the memory `waitrequest` handshake, latches the fetched instruction and load data, and detects halt and bus-timeout conditions.
- Counts retired instructions and sits between the Avalon-style memory port and the decoder/datapath.

Parameters:
- WAIT_TIMEOUT, 1024: consecutive stalled cycles before bus error; 0 disables the timeout.
- COUNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- waitrequest  input  1  memory busy; the current access is not complete
- readdata  input  32  memory read data
- halt  input  1  from decoder: PC == 0
- extra  input  1  from decoder: the current instruction needs EXEC2 (loads)
- mem_access  input  1  from decoder: MemRead or MemWrite asserted in EXEC1
- state  output  2  00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT
- fetch_read  output  1  instruction read strobe
- instr_reg  output  32  latched instruction
- data_reg  output  32  latched load data
- active  output  1  1 while the CPU is running
- bus_error  output  1  sticky; set when the timeout expires
- retired  output  COUNT_W  number of instructions completed (wraps)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, instr_reg=0, data_reg=0, active=1, bus_error=0, retired=0, wait_cnt=0.
  - Reset mid-access aborts the access immediately with no completion.
- FETCH:
  - If halt=1: fetch_read=0 and next state is HALT.
  - Otherwise fetch_read=1.
  - If waitrequest=1, stay in FETCH.
  - If waitrequest=0, instr_reg<=readdata and next state is EXEC1.
  - halt has priority over waitrequest.
- EXEC1:
  - stall = mem_access & waitrequest. If stall, stay in EXEC1.
  - Otherwise, if extra=1: data_reg<=readdata and next state is EXEC2.
  - Otherwise next state is FETCH and retired increments.
- EXEC2:
  - Unconditionally next state is FETCH, retired increments. Lasts exactly one cycle.
- HALT:
  - Absorbing state; only reset exits.
  - active=0 (registered, deasserts on the edge entering HALT).
  - fetch_read=0; instr_reg, data_reg and retired hold.
- fetch_read is combinational from state and halt; it is 0 in EXEC1, EXEC2 and HALT.
- Timeout:
  - wait_cnt increments on every stalled cycle: FETCH with waitrequest=1, or EXEC1 with stall=1.
  - wait_cnt clears on any non-stalled cycle.
  - When WAIT_TIMEOUT≠0 and a stalled cycle occurs with wait_cnt==WAIT_TIMEOUT-1: next state is HALT, bus_error<=1, and instr_reg/data_reg are not updated.
  - wait_cnt saturates and is sized clog2(WAIT_TIMEOUT+1).
- retired wraps modulo 2^COUNT_W without a flag.
- Latency:
  - Zero-wait non-memory instruction: 2 cycles.
  - Zero-wait load: 3 cycles.
  - Each waitrequest cycle adds 1 cycle.
- In EXEC1 without mem_access, waitrequest is ignored.
- Encoding 2'b11 is used only for HALT; no other unreachable encodings exist.

Test Plan:
- Reset release, halt=0, waitrequest=0, readdata=0x24020005, extra=0, mem_access=0:
  - state sequence 00,01,00,01…
  - instr_reg=0x24020005 in EXEC1.
  - retired=1 after the first EXEC1 cycle.
- Load with extra=1, mem_access=1, waitrequest high for 3 EXEC1 cycles, readdata=0xDEADBEEF on release:
  - EXEC1 held for 3 extra cycles, then EXEC2.
  - data_reg=0xDEADBEEF.
  - retired increments once, on EXEC2→FETCH.
- halt=1 asserted in FETCH while waitrequest=1:
  - fetch_read=0.
  - Next state 11, active=0.
  - Stays in HALT for 100 cycles, retired unchanged.
- WAIT_TIMEOUT=4, waitrequest stuck high in FETCH:
  - State 00 for 4 cycles, then 11.
  - bus_error=1, instr_reg unchanged.
  - WAIT_TIMEOUT=0 variant: no HALT after 10000 cycles.
- EXEC1 with mem_access=0, waitrequest=1:
  - Returns to FETCH the next cycle, wait_cnt not incremented.
- reset pulsed low during an EXEC1 stall, asynchronously between edges:
  - All outputs reach reset values without waiting for a clock edge.
  - After release, state=00 and bus_error=0.

Source files
------------

// File: rtl/mips_cycle_controller_if.sv
// mips_cycle_controller_if: Avalon-style instruction/data memory port
interface mips_cycle_controller_if;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        fetch_read;
  modport master (input waitrequest, input readdata, output fetch_read);
  modport slave  (output waitrequest, output readdata, input fetch_read);
endinterface

// File: rtl/mips_cycle_controller.sv
// mips_cycle_controller: multi-cycle FETCH/EXEC1/EXEC2/HALT sequencer with bus timeout
module mips_cycle_controller #(
  parameter int WAIT_TIMEOUT = 1024,
  parameter int COUNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_cycle_controller_if.master   mem,
  input  logic                      halt,
  input  logic                      extra,
  input  logic                      mem_access,
  output logic [1:0]                state,
  output logic [31:0]               instr_reg,
  output logic [31:0]               data_reg,
  output logic                      active,
  output logic                      bus_error,
  output logic [COUNT_W-1:0]        retired
);
  localparam int CW = WAIT_TIMEOUT > 0 ? $clog2(WAIT_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC1 = 2'b01, EXEC2 = 2'b10, HALT = 2'b11} state_e;
  state_e               state_q, state_d;
  logic [31:0]          instr_q, instr_d, data_q, data_d;
  logic                 active_q, active_d, bus_error_q, bus_error_d;
  logic [COUNT_W-1:0]   retired_q, retired_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 stall, timeout;
  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      instr_q     <= '0;
      data_q      <= '0;
      active_q    <= 1'b1;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
      active_q    <= active_d;
      bus_error_q <= bus_error_d;
      retired_q   <= retired_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end
  // Next state, stall/timeout detection and register updates
  always_comb begin
    stall       = (state_q == FETCH && !halt && mem.waitrequest) ||
                  (state_q == EXEC1 && mem_access && mem.waitrequest);
    timeout     = (WAIT_TIMEOUT != 0) && stall && (wait_cnt_q == CW'(WAIT_TIMEOUT - 1));
    state_d     = state_q;
    instr_d     = instr_q;
    data_d      = data_q;
    retired_d   = retired_q;
    wait_cnt_d  = stall ? ((&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1) : '0;
    bus_error_d = bus_error_q | timeout;
    case (state_q)
      FETCH: begin
        if (halt) state_d = HALT;
        else if (timeout) state_d = HALT;
        else if (!mem.waitrequest) begin
          instr_d = mem.readdata;
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        if (timeout) state_d = HALT;
        else if (!stall && extra) begin
          data_d  = mem.readdata;
          state_d = EXEC2;
        end else if (!stall) begin
          retired_d = retired_q + 1'b1;
          state_d   = FETCH;
        end
      end
      EXEC2: begin
        retired_d = retired_q + 1'b1;
        state_d   = FETCH;
      end
      default: state_d = HALT;
    endcase
    active_d = state_d != HALT;
  end
  // Outputs: fetch strobe is combinational so halt suppresses it in the same cycle
  always_comb begin
    mem.fetch_read = state_q == FETCH && !halt;
    state          = state_q;
    instr_reg      = instr_q;
    data_reg       = data_q;
    active         = active_q;
    bus_error      = bus_error_q;
    retired        = retired_q;
  end
endmodule

// File: tb/tb_mips_cycle_controller.sv
// tb_mips_cycle_controller: scoreboard bench with a cycle-level reference model
module tb_mips_cycle_controller;
  localparam int WT = 4;
  typedef struct {
    logic [1:0]  st;
    logic        fr;
    logic [31:0] ir;
    logic [31:0] dr;
    logic        act;
    logic        be;
    logic [3:0]  ret;
  } exp_t;
  logic clk = 1'b0;
  logic reset, halt, extra, mem_access;
  logic [1:0]  state;
  logic [31:0] instr_reg, data_reg;
  logic        active, bus_error;
  logic [3:0]  retired;
  logic reset0, halt0, extra0, ma0;
  logic [1:0]  state0;
  logic [31:0] ir0, dr0, ret0;
  logic        act0, be0;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cycles = 0;
  int ph, m_wc, m_ret, hcnt;
  logic [31:0] m_ir, m_dr;
  logic m_be;
  mips_cycle_controller_if bus();
  mips_cycle_controller_if bus0();
  always #5 clk = ~clk;
  mips_cycle_controller #(.WAIT_TIMEOUT(WT), .COUNT_W(4)) dut (
    .clk(clk), .reset(reset), .mem(bus), .halt(halt), .extra(extra), .mem_access(mem_access),
    .state(state), .instr_reg(instr_reg), .data_reg(data_reg), .active(active),
    .bus_error(bus_error), .retired(retired));
  mips_cycle_controller #(.WAIT_TIMEOUT(0), .COUNT_W(32)) dut0 (
    .clk(clk), .reset(reset0), .mem(bus0), .halt(halt0), .extra(extra0), .mem_access(ma0),
    .state(state0), .instr_reg(ir0), .data_reg(dr0), .active(act0),
    .bus_error(be0), .retired(ret0));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask
  // Reference: an instruction is fetched, optionally loads, then retires; WT consecutive stalls kill the bus
  task automatic step(input logic h, input logic w, input logic ex, input logic ma, input logic [31:0] rd);
    bit stl;
    if (ph == 3) return;
    stl = (ph == 0 && !h && w) || (ph == 1 && ma && w);
    if (stl) begin
      m_wc++;
      if (m_wc == WT) begin ph = 3; m_be = 1'b1; end
    end else begin
      m_wc = 0;
      if (ph == 0) begin
        if (h) ph = 3;
        else begin m_ir = rd; ph = 1; end
      end else if (ph == 1) begin
        if (ex) begin m_dr = rd; ph = 2; end
        else begin m_ret = (m_ret + 1) % 16; ph = 0; end
      end else begin
        m_ret = (m_ret + 1) % 16;
        ph = 0;
      end
    end
  endtask
  task automatic cyc(input logic r, input logic h, input logic w, input logic ex, input logic ma, input logic [31:0] rd);
    exp_t e;
    @(posedge clk);
    #2;
    cycles++;
    reset = r; halt = h; bus.waitrequest = w; extra = ex; mem_access = ma; bus.readdata = rd;
    if (!r) begin ph = 0; m_wc = 0; m_ret = 0; m_ir = '0; m_dr = '0; m_be = 1'b0; end
    e.st = 2'(ph); e.fr = (ph == 0) && !h; e.ir = m_ir; e.dr = m_dr;
    e.act = ph != 3; e.be = m_be; e.ret = 4'(m_ret);
    q.push_back(e);
    if (r) step(h, w, ex, ma, rd);
  endtask
  task automatic to_fetch();
    if (ph == 3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    while (ph != 0) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic rnd_cyc();
    logic r, h;
    if (ph == 3) hcnt++; else hcnt = 0;
    r = !(hcnt > 8 || $urandom_range(0, 199) == 0);
    h = $urandom_range(0, 49) == 0 && !(ph == 0 && m_wc == WT - 1);
    cyc(r, h, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), $urandom);
  endtask
  // Monitor: compare every presented cycle against the oldest model expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("fetch_read", 32'(bus.fetch_read), 32'(e.fr));
      chk("instr_reg", instr_reg, e.ir);
      chk("data_reg", data_reg, e.dr);
      chk("active", 32'(active), 32'(e.act));
      chk("bus_error", 32'(bus_error), 32'(e.be));
      chk("retired", 32'(retired), 32'(e.ret));
    end
  end
  initial begin
    reset = 1'b0; halt = 1'b0; extra = 1'b0; mem_access = 1'b0;
    bus.waitrequest = 1'b0; bus.readdata = '0;
    reset0 = 1'b0; halt0 = 1'b0; extra0 = 1'b0; ma0 = 1'b0;
    bus0.waitrequest = 1'b1; bus0.readdata = 32'h1234_5678;
    ph = 0; m_wc = 0; m_ret = 0; m_ir = '0; m_dr = '0; m_be = 1'b0; hcnt = 0;
    #12 reset0 = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2402_0005);
    to_fetch();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8C43_0000);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    to_fetch();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (100) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1111);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (6) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2222);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3333);
    to_fetch();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_4444);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3000) rnd_cyc();
    while (cycles < 10050) rnd_cyc();
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 32'd0);
    chk("nt_state", 32'(state0), 32'd0);
    chk("nt_bus_error", 32'(be0), 32'd0);
    chk("nt_active", 32'(act0), 32'd1);
    chk("nt_fetch_read", 32'(bus0.fetch_read), 32'd1);
    chk("nt_instr", ir0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
